// File: rtl/decode_pkg.sv
// decode_pkg: opcode constants, ID/EX bundle type and the control/immediate
// decode helpers shared by the decode/issue stage.
// Optional feature macro: DECODE_WB_BYPASS_EN (writeback bypass into register
// reads and same-cycle scoreboard clear).
package decode_pkg;

  localparam int XLEN              = 32;
  localparam int ALU_CONTROL_WIDTH = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;

  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CONTROL_WIDTH-1:0] ALU_SUB = 4'b1000;

`ifdef DECODE_WB_BYPASS_EN
  localparam bit WB_BYPASS = 1'b1;
`else
  localparam bit WB_BYPASS = 1'b0;
`endif

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'b00,
    ALU_A_PC   = 2'b01,
    ALU_A_ZERO = 2'b10
  } alu_a_src_sel_e;

  typedef enum logic {
    PC_TGT_PC  = 1'b0,
    PC_TGT_RS1 = 1'b1
  } pc_target_src_sel_e;

  typedef struct packed {
    logic                         reg_write;
    logic                         mem_write;
    logic                         jump;
    logic                         branch;
    logic                         alu_src;
    logic [1:0]                   result_src;
    logic [ALU_CONTROL_WIDTH-1:0] alu_control;
    alu_a_src_sel_e               op_a_sel;
    pc_target_src_sel_e           pc_target_src_sel;
  } ctrl_t;

  typedef struct packed {
    logic                         reg_write;
    logic                         mem_write;
    logic                         jump;
    logic                         branch;
    logic                         alu_src;
    logic [1:0]                   result_src;
    logic [ALU_CONTROL_WIDTH-1:0] alu_control;
    logic [2:0]                   funct3;
    alu_a_src_sel_e               op_a_sel;
    pc_target_src_sel_e           pc_target_src_sel;
    logic [XLEN-1:0]              pc;
    logic [XLEN-1:0]              pc_plus_4;
    logic [XLEN-1:0]              imm;
    logic [XLEN-1:0]              rs1_data;
    logic [XLEN-1:0]              rs2_data;
    logic [4:0]                   rs1_addr;
    logic [4:0]                   rs2_addr;
    logic [4:0]                   rd_addr;
    logic                         illegal;
  } id_ex_bundle_t;

  // Main control decode for the RV32I base opcodes.
  function automatic ctrl_t control_unit(input logic [31:0] instr);
    ctrl_t      c;
    logic [2:0] f3;
    c  = '0;
    f3 = instr[14:12];
    case (instr[6:0])
      OPC_LUI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.op_a_sel  = ALU_A_ZERO;
      end
      OPC_AUIPC: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.op_a_sel  = ALU_A_PC;
      end
      OPC_JAL: begin
        c.reg_write  = 1'b1;
        c.jump       = 1'b1;
        c.result_src = RESULT_SRC_PC4;
      end
      OPC_JALR: begin
        c.reg_write         = 1'b1;
        c.jump              = 1'b1;
        c.alu_src           = 1'b1;
        c.result_src        = RESULT_SRC_PC4;
        c.pc_target_src_sel = PC_TGT_RS1;
      end
      OPC_BRANCH: begin
        c.branch      = 1'b1;
        c.alu_control = ALU_SUB;
      end
      OPC_LOAD: begin
        c.reg_write  = 1'b1;
        c.alu_src    = 1'b1;
        c.result_src = RESULT_SRC_LOAD;
      end
      OPC_STORE: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OPC_OP_IMM: begin
        c.reg_write   = 1'b1;
        c.alu_src     = 1'b1;
        // Only the shift-right pair uses bit 30 as an operation selector.
        c.alu_control = (f3 == 3'b101) ? {instr[30], f3} : {1'b0, f3};
      end
      OPC_OP: begin
        c.reg_write   = 1'b1;
        c.alu_control = {instr[30], f3};
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Sign-extended immediate for each instruction format.
  function automatic logic [31:0] immediate_generator(input logic [31:0] instr);
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        return {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        return {instr[31:12], 12'b0};
      OPC_JAL:
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        return 32'd0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH);
  endfunction

  // True when a 5-bit register index does not exist in a file of num_regs entries.
  function automatic logic reg_oob(input logic [4:0] idx, input int num_regs);
    return int'(idx) >= num_regs;
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// decode_issue_if: fetch -> decode valid/ready handshake carrying the
// instruction word and its PC / PC+4.
interface decode_issue_if
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN
);
  logic                  if_valid;
  logic                  if_ready;
  logic [31:0]           instr;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_plus_4;

  modport master (output if_valid, instr, pc, pc_plus_4, input if_ready);
  modport slave  (input if_valid, instr, pc, pc_plus_4, output if_ready);
endinterface

// File: rtl/decode_issue_load_scoreboard.sv
// load_scoreboard: one pending bit per architectural register tracking loads
// that have issued but not yet written back, plus the RAW/WAW hazard query.
// Same-cycle writeback clears unblock the query only with DECODE_WB_BYPASS_EN.
module load_scoreboard
  import decode_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en_i,
  input  logic [4:0] set_addr_i,
  input  logic       clr_en_i,
  input  logic [4:0] clr_addr_i,
  input  logic       flush_clr_en_i,
  input  logic [4:0] flush_clr_addr_i,
  input  logic       rs1_used_i,
  input  logic [4:0] rs1_addr_i,
  input  logic       rs2_used_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       rd_check_i,
  input  logic [4:0] rd_addr_i,
  output logic       hazard_o
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                rs1_busy, rs2_busy, rd_busy;

  function automatic logic pend_at(input logic [NUM_REGS-1:0] v, input logic [4:0] a);
    if (reg_oob(a, NUM_REGS)) return 1'b0;
    return v[a[AW-1:0]];
  endfunction

  // Pending-bit update: clears first, then a same-cycle set overrides them.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      if ((clr_en_i && clr_addr_i == 5'(r)) ||
          (flush_clr_en_i && flush_clr_addr_i == 5'(r)))
        pend_d[r] = 1'b0;
      if (set_en_i && set_addr_i == 5'(r))
        pend_d[r] = 1'b1;
    end
  end

  // Pending-bit state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  // Hazard query: a source still waiting on its load, or a load whose rd is already pending.
  always_comb begin
    rs1_busy = rs1_used_i && pend_at(pend_q, rs1_addr_i) &&
               !(WB_BYPASS && clr_en_i && clr_addr_i == rs1_addr_i);
    rs2_busy = rs2_used_i && pend_at(pend_q, rs2_addr_i) &&
               !(WB_BYPASS && clr_en_i && clr_addr_i == rs2_addr_i);
    rd_busy  = rd_check_i && pend_at(pend_q, rd_addr_i);
    hazard_o = rs1_busy || rs2_busy || rd_busy;
  end

endmodule

// File: rtl/decode_issue.sv
// decode_issue: registered RV32 decode/issue stage. Decodes the fetched
// instruction, reads the internal register file, stalls on pending loads and
// issues an ID/EX bundle from a flushable, back-pressurable output register
// that snoops writeback while held.
// Optional feature macro: DECODE_WB_BYPASS_EN (handled through decode_pkg::WB_BYPASS).
module decode_issue
  import decode_pkg::*;
#(
  parameter int DATA_WIDTH     = XLEN,
  parameter int NUM_REGS       = 32,
  parameter int REG_ADDR_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  decode_issue_if.slave                fetch,
  input  logic                         wb_en_i,
  input  logic [4:0]                   wb_addr_i,
  input  logic [DATA_WIDTH-1:0]        wb_data_i,
  input  logic                         wb_load_i,
  input  logic                         flush_i,
  output logic                         stall_o,
  output logic                         ex_valid_o,
  input  logic                         ex_ready_i,
  output logic                         ex_reg_write_o,
  output logic                         ex_mem_write_o,
  output logic                         ex_jump_o,
  output logic                         ex_branch_o,
  output logic                         ex_alu_src_o,
  output logic [1:0]                   ex_result_src_o,
  output logic [ALU_CONTROL_WIDTH-1:0] ex_alu_control_o,
  output logic [2:0]                   ex_funct3_o,
  output alu_a_src_sel_e               ex_op_a_sel_o,
  output pc_target_src_sel_e           ex_pc_target_src_sel_o,
  output logic [DATA_WIDTH-1:0]        ex_pc_o,
  output logic [DATA_WIDTH-1:0]        ex_pc_plus_4_o,
  output logic [DATA_WIDTH-1:0]        ex_imm_o,
  output logic [DATA_WIDTH-1:0]        ex_rs1_data_o,
  output logic [DATA_WIDTH-1:0]        ex_rs2_data_o,
  output logic [4:0]                   ex_rs1_addr_o,
  output logic [4:0]                   ex_rs2_addr_o,
  output logic [4:0]                   ex_rd_addr_o,
  output logic                         ex_illegal_o
);

  logic [DATA_WIDTH-1:0] rf_q [NUM_REGS];
  id_ex_bundle_t         ex_q, ex_d, dec;
  logic                  ex_valid_q, ex_valid_d;

  ctrl_t                 ctrl;
  logic [6:0]            opc;
  logic [4:0]            rs1_a, rs2_a, rd_a;
  logic                  use_rs1, use_rs2, illegal, is_load;
  logic                  wb_wr, hazard, advance, issue;
  logic                  flush_clr;
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val;

  assign opc     = fetch.instr[6:0];
  assign rd_a    = fetch.instr[11:7];
  assign rs1_a   = fetch.instr[19:15];
  assign rs2_a   = fetch.instr[24:20];
  assign ctrl    = control_unit(fetch.instr);
  assign use_rs1 = uses_rs1(opc);
  assign use_rs2 = uses_rs2(opc);
  assign illegal = (use_rs1 && reg_oob(rs1_a, NUM_REGS)) ||
                   (use_rs2 && reg_oob(rs2_a, NUM_REGS)) ||
                   (ctrl.reg_write && reg_oob(rd_a, NUM_REGS));
  // Only a legal load with a real destination ever owns a scoreboard bit.
  assign is_load = (ctrl.result_src == RESULT_SRC_LOAD) && ctrl.reg_write &&
                   (rd_a != 5'd0) && !illegal;
  assign wb_wr   = wb_en_i && (wb_addr_i != 5'd0) && !reg_oob(wb_addr_i, NUM_REGS);

  assign advance        = !ex_valid_q || ex_ready_i;
  assign fetch.if_ready = advance && !hazard && !flush_i;
  assign issue          = fetch.if_valid && fetch.if_ready;
  assign stall_o        = fetch.if_valid && hazard;
  // A load killed in the output register will never write back, so release its bit.
  assign flush_clr      = flush_i && ex_valid_q && ex_q.reg_write &&
                          (ex_q.result_src == RESULT_SRC_LOAD) && (ex_q.rd_addr != 5'd0);

  load_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk              (clk),
    .rst              (rst),
    .set_en_i         (issue && is_load),
    .set_addr_i       (rd_a),
    .clr_en_i         (wb_en_i && wb_load_i),
    .clr_addr_i       (wb_addr_i),
    .flush_clr_en_i   (flush_clr),
    .flush_clr_addr_i (ex_q.rd_addr),
    .rs1_used_i       (use_rs1),
    .rs1_addr_i       (rs1_a),
    .rs2_used_i       (use_rs2),
    .rs2_addr_i       (rs2_a),
    .rd_check_i       (is_load),
    .rd_addr_i        (rd_a),
    .hazard_o         (hazard)
  );

  // Register file write port; x0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) rf_q[r] <= '0;
    end else if (wb_wr) begin
      rf_q[wb_addr_i[REG_ADDR_WIDTH-1:0]] <= wb_data_i;
    end
  end

  // Register file reads, optionally bypassing the writeback in flight.
  always_comb begin
    rs1_val = rf_q[rs1_a[REG_ADDR_WIDTH-1:0]];
    rs2_val = rf_q[rs2_a[REG_ADDR_WIDTH-1:0]];
    if (WB_BYPASS && wb_wr && wb_addr_i == rs1_a) rs1_val = wb_data_i;
    if (WB_BYPASS && wb_wr && wb_addr_i == rs2_a) rs2_val = wb_data_i;
  end

  // Assemble the decoded bundle; an illegal index suppresses architectural side effects.
  always_comb begin
    dec                   = '0;
    dec.reg_write         = ctrl.reg_write && !illegal;
    dec.mem_write         = ctrl.mem_write && !illegal;
    dec.jump              = ctrl.jump;
    dec.branch            = ctrl.branch;
    dec.alu_src           = ctrl.alu_src;
    dec.result_src        = ctrl.result_src;
    dec.alu_control       = ctrl.alu_control;
    dec.funct3            = fetch.instr[14:12];
    dec.op_a_sel          = ctrl.op_a_sel;
    dec.pc_target_src_sel = ctrl.pc_target_src_sel;
    dec.pc                = fetch.pc;
    dec.pc_plus_4         = fetch.pc_plus_4;
    dec.imm               = immediate_generator(fetch.instr);
    dec.rs1_data          = rs1_val;
    dec.rs2_data          = rs2_val;
    dec.rs1_addr          = rs1_a;
    dec.rs2_addr          = rs2_a;
    dec.rd_addr           = rd_a;
    dec.illegal           = illegal;
  end

  // Output register next state: flush, then issue, then drain, else hold with WB snoop.
  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (issue) begin
      ex_valid_d = 1'b1;
      ex_d       = dec;
    end else if (advance) begin
      ex_valid_d = 1'b0;
    end else begin
      if (wb_en_i && ex_q.rs1_addr != 5'd0 && wb_addr_i == ex_q.rs1_addr)
        ex_d.rs1_data = wb_data_i;
      if (wb_en_i && ex_q.rs2_addr != 5'd0 && wb_addr_i == ex_q.rs2_addr)
        ex_d.rs2_data = wb_data_i;
    end
  end

  // Output register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  assign ex_valid_o             = ex_valid_q;
  assign ex_reg_write_o         = ex_q.reg_write;
  assign ex_mem_write_o         = ex_q.mem_write;
  assign ex_jump_o              = ex_q.jump;
  assign ex_branch_o            = ex_q.branch;
  assign ex_alu_src_o           = ex_q.alu_src;
  assign ex_result_src_o        = ex_q.result_src;
  assign ex_alu_control_o       = ex_q.alu_control;
  assign ex_funct3_o            = ex_q.funct3;
  assign ex_op_a_sel_o          = ex_q.op_a_sel;
  assign ex_pc_target_src_sel_o = ex_q.pc_target_src_sel;
  assign ex_pc_o                = ex_q.pc;
  assign ex_pc_plus_4_o         = ex_q.pc_plus_4;
  assign ex_imm_o               = ex_q.imm;
  assign ex_rs1_data_o          = ex_q.rs1_data;
  assign ex_rs2_data_o          = ex_q.rs2_data;
  assign ex_rs1_addr_o          = ex_q.rs1_addr;
  assign ex_rs2_addr_o          = ex_q.rs2_addr;
  assign ex_rd_addr_o           = ex_q.rd_addr;
  assign ex_illegal_o           = ex_q.illegal;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed bench for decode_issue (32-register instance plus
// a 16-register instance sharing the same stimulus).
module tb_decode_issue;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid, wb_en, wb_load, flush, ex_ready;
  logic [31:0] instr, pc, pc4, wb_data;
  logic [4:0]  wb_addr;
  int          n_chk = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  decode_issue_if #(.DATA_WIDTH(32)) f32 ();
  decode_issue_if #(.DATA_WIDTH(32)) f16 ();

  assign f32.if_valid  = if_valid;
  assign f32.instr     = instr;
  assign f32.pc        = pc;
  assign f32.pc_plus_4 = pc4;
  assign f16.if_valid  = if_valid;
  assign f16.instr     = instr;
  assign f16.pc        = pc;
  assign f16.pc_plus_4 = pc4;

  logic stall32, exv32, rw32, mw32, j32, br32, as32, ill32;
  logic [1:0] rs32; logic [3:0] alu32; logic [2:0] f3_32;
  alu_a_src_sel_e opa32; pc_target_src_sel_e tgt32;
  logic [31:0] pc32, pc4_32, imm32, d1_32, d2_32;
  logic [4:0] a1_32, a2_32, rd32;

  logic stall16, exv16, rw16, mw16, j16, br16, as16, ill16;
  logic [1:0] rs16; logic [3:0] alu16; logic [2:0] f3_16;
  alu_a_src_sel_e opa16; pc_target_src_sel_e tgt16;
  logic [31:0] pc16, pc4_16, imm16, d1_16, d2_16;
  logic [4:0] a1_16, a2_16, rd16;

  decode_issue #(.NUM_REGS(32)) dut (
    .clk(clk), .rst(rst), .fetch(f32.slave),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_load_i(wb_load),
    .flush_i(flush), .stall_o(stall32), .ex_valid_o(exv32), .ex_ready_i(ex_ready),
    .ex_reg_write_o(rw32), .ex_mem_write_o(mw32), .ex_jump_o(j32), .ex_branch_o(br32),
    .ex_alu_src_o(as32), .ex_result_src_o(rs32), .ex_alu_control_o(alu32),
    .ex_funct3_o(f3_32), .ex_op_a_sel_o(opa32), .ex_pc_target_src_sel_o(tgt32),
    .ex_pc_o(pc32), .ex_pc_plus_4_o(pc4_32), .ex_imm_o(imm32),
    .ex_rs1_data_o(d1_32), .ex_rs2_data_o(d2_32), .ex_rs1_addr_o(a1_32),
    .ex_rs2_addr_o(a2_32), .ex_rd_addr_o(rd32), .ex_illegal_o(ill32)
  );

  decode_issue #(.NUM_REGS(16)) dut16 (
    .clk(clk), .rst(rst), .fetch(f16.slave),
    .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_load_i(wb_load),
    .flush_i(flush), .stall_o(stall16), .ex_valid_o(exv16), .ex_ready_i(ex_ready),
    .ex_reg_write_o(rw16), .ex_mem_write_o(mw16), .ex_jump_o(j16), .ex_branch_o(br16),
    .ex_alu_src_o(as16), .ex_result_src_o(rs16), .ex_alu_control_o(alu16),
    .ex_funct3_o(f3_16), .ex_op_a_sel_o(opa16), .ex_pc_target_src_sel_o(tgt16),
    .ex_pc_o(pc16), .ex_pc_plus_4_o(pc4_16), .ex_imm_o(imm16),
    .ex_rs1_data_o(d1_16), .ex_rs2_data_o(d2_16), .ex_rs1_addr_o(a1_16),
    .ex_rs2_addr_o(a2_16), .ex_rd_addr_o(rd16), .ex_illegal_o(ill16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p);
    if_valid = 1'b1;
    instr    = i;
    pc       = p;
    pc4      = p + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; if_valid = 1'b0; instr = '0; pc = '0; pc4 = '0;
    wb_en = 1'b0; wb_load = 1'b0; wb_addr = '0; wb_data = '0;
    flush = 1'b0; ex_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", exv32, 0);
    chk("rst_imm", imm32, 0);
    chk("rst_rd", rd32, 0);
    chk("rst_regwrite", rw32, 0);
    chk("rst_valid16", exv16, 0);
    rst = 1'b0;

    // addi x1,x0,5
    drive(32'h00500093, 32'h100); #1;
    chk("addi_ready", f32.if_ready, 1);
    chk("addi_stall", stall32, 0);
    tick(); if_valid = 1'b0; #1;
    chk("addi_valid", exv32, 1);
    chk("addi_imm", imm32, 5);
    chk("addi_rd", rd32, 1);
    chk("addi_regwrite", rw32, 1);
    chk("addi_alusrc", as32, 1);
    chk("addi_pc", pc32, 32'h100);
    chk("addi_pc4", pc4_32, 32'h104);

    // lw x2,0(x1) then add x3,x2,x2
    drive(32'h0000A103, 32'h104); #1;
    chk("lw_ready", f32.if_ready, 1);
    tick(); drive(32'h002101B3, 32'h108); #1;
    chk("lw_valid", exv32, 1);
    chk("lw_resultsrc", rs32, 1);
    chk("lw_rd", rd32, 2);
    chk("lu_stall", stall32, 1);
    chk("lu_ready", f32.if_ready, 0);
    tick(); #1;
    chk("lu_bubble_valid", exv32, 0);
    chk("lu_stall2", stall32, 1);
    wb_en = 1'b1; wb_load = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEAD; #1;
`ifdef DECODE_WB_BYPASS_EN
    chk("lu_wb_stall", stall32, 0);
    chk("lu_wb_ready", f32.if_ready, 1);
    tick(); wb_en = 1'b0; wb_load = 1'b0; if_valid = 1'b0; #1;
`else
    chk("lu_wb_stall", stall32, 1);
    tick(); wb_en = 1'b0; wb_load = 1'b0; #1;
    chk("lu_post_valid", exv32, 0);
    chk("lu_post_stall", stall32, 0);
    chk("lu_post_ready", f32.if_ready, 1);
    tick(); if_valid = 1'b0; #1;
`endif
    chk("add_valid", exv32, 1);
    chk("add_rd", rd32, 3);
    chk("add_rs1data", d1_32, 32'hDEAD);
    chk("add_rs2data", d2_32, 32'hDEAD);
    chk("add_rs1addr", a1_32, 2);

    // hold with writeback snoop: sub x4,x5,x6 with x5=0x11, x6=0x22
    tick();
    wb_en = 1'b1; wb_load = 1'b0; wb_addr = 5'd5; wb_data = 32'h11;
    tick(); wb_addr = 5'd6; wb_data = 32'h22;
    tick(); wb_en = 1'b0;
    ex_ready = 1'b0; drive(32'h40628233, 32'h200); #1;
    chk("sub_ready", f32.if_ready, 1);
    tick(); drive(32'h00500093, 32'h204); #1;
    chk("sub_valid", exv32, 1);
    chk("sub_rs1data", d1_32, 32'h11);
    chk("sub_rs2data", d2_32, 32'h22);
    chk("sub_alu", alu32, 4'b1000);
    chk("hold_ready", f32.if_ready, 0);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h77;
    tick(); wb_en = 1'b0; #1;
    chk("hold_valid", exv32, 1);
    chk("hold_rs1data", d1_32, 32'h77);
    chk("hold_rs2data", d2_32, 32'h22);
    chk("hold_rd", rd32, 4);
    chk("hold_alu", alu32, 4'b1000);
    chk("hold_pc", pc32, 32'h200);
    chk("hold_ready2", f32.if_ready, 0);
    if_valid = 1'b0; ex_ready = 1'b1;
    tick(); #1;
    chk("drain_valid", exv32, 0);

    // flush a held load to x7, then a dependent add issues at once
    ex_ready = 1'b0; drive(32'h0000A383, 32'h300); #1;
    tick(); drive(32'h00038433, 32'h304); #1;
    chk("ld7_valid", exv32, 1);
    chk("ld7_rd", rd32, 7);
    chk("ld7_stall", stall32, 1);
    flush = 1'b1; #1;
    chk("flush_ready", f32.if_ready, 0);
    tick(); flush = 1'b0; #1;
    chk("flush_valid", exv32, 0);
    chk("flush_stall", stall32, 0);
    chk("flush_ready2", f32.if_ready, 1);
    tick(); #1;
    chk("add8_valid", exv32, 1);
    chk("add8_rd", rd32, 8);
    chk("add8_rs1addr", a1_32, 7);
    if_valid = 1'b0; ex_ready = 1'b1;
    tick();

    // sw x6,-4(x5)
    drive(32'hFE62AE23, 32'h400); #1;
    tick(); if_valid = 1'b0; #1;
    chk("sw_imm", imm32, 32'hFFFFFFFC);
    chk("sw_memwrite", mw32, 1);
    chk("sw_regwrite", rw32, 0);
    chk("sw_rs1data", d1_32, 32'h77);
    chk("sw_rs2data", d2_32, 32'h22);

    // add x17,x1,x2 on both register file sizes
    drive(32'h002088B3, 32'h500); #1;
    tick(); if_valid = 1'b0; #1;
    chk("x17_illegal32", ill32, 0);
    chk("x17_regwrite32", rw32, 1);
    chk("x17_rd32", rd32, 17);
    chk("x17_valid16", exv16, 1);
    chk("x17_illegal16", ill16, 1);
    chk("x17_regwrite16", rw16, 0);
    chk("x17_memwrite16", mw16, 0);

    // reset in the middle of a load, then a reader of its rd sees no stall
    tick();
    drive(32'h0000A483, 32'h600); #1;
    tick(); if_valid = 1'b0; #1;
    chk("ld9_valid", exv32, 1);
    #2 rst = 1'b1; #1;
    chk("midrst_valid", exv32, 0);
    chk("midrst_rd", rd32, 0);
    tick(); rst = 1'b0;
    drive(32'h00248533, 32'h604); #1;
    chk("postrst_stall", stall32, 0);
    chk("postrst_ready", f32.if_ready, 1);
    tick(); if_valid = 1'b0; #1;
    chk("postrst_valid", exv32, 1);
    chk("postrst_rs2data", d2_32, 0);
    chk("postrst_rs1addr", a1_32, 9);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
# decode_issue

Registered decode/issue stage for the RV32 pipeline. It accepts fetched instructions over a valid/ready handshake and decodes them through the existing control and immediate logic. It reads an internal parametrised register file and stalls on pending load results using a per-register scoreboard. It then issues a complete ID/EX bundle from its own output register, which is flushable and back-pressurable and snoops writeback while stalled.

## Interface
- DATA_WIDTH, 32, register/PC/immediate width
- NUM_REGS, 32, architectural registers (32 or 16 for RV32E)
- REG_ADDR_WIDTH, $clog2(NUM_REGS), register index width
- clk  in  1  clock
- rst  in  1  reset, asynchronous and active-high
- if_valid_i / if_ready_o  in/out  1  fetch handshake
- instr_i  in  32  instruction
- pc_i, pc_plus_4_i  in  DATA_WIDTH  PC and PC+4 of instr_i
- wb_en_i  in  1  writeback write enable
- wb_addr_i  in  5  writeback destination
- wb_data_i  in  DATA_WIDTH  writeback data
- wb_load_i  in  1  writeback result comes from a load
- flush_i  in  1  kill the decode input and the output register
- stall_o  out  1  hazard stall this cycle
- ex_valid_o / ex_ready_i  out/in  1  issue handshake
- ex_reg_write_o, ex_mem_write_o, ex_jump_o, ex_branch_o, ex_alu_src_o  out  1 each  control
- ex_result_src_o  out  2  result mux select (2'b01 = load)
- ex_alu_control_o  out  ALU_CONTROL_WIDTH  ALU operation
- ex_funct3_o  out  3  funct3
- ex_op_a_sel_o  out  alu_a_src_sel_e  operand A source
- ex_pc_target_src_sel_o  out  pc_target_src_sel_e  target base
- ex_pc_o, ex_pc_plus_4_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o  out  DATA_WIDTH  data
- ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  5  register indices
- ex_illegal_o  out  1  register index out of range for NUM_REGS

## Operation
- Register file: NUM_REGS×DATA_WIDTH, x0 reads 0 and writes to it are ignored, written on wb_en_i.
- Usage: rs1 is used by every opcode except LUI, AUIPC and JAL. rs2 is used only by R, S and B types.
- Scoreboard: one pending bit per register.
  - Set when a load (result_src 2'b01, rd≠0) issues.
  - Cleared on wb_en_i && wb_load_i && wb_addr_i==r.
  - Also cleared when flush_i kills a valid load held in the output register.
  - If set and clear hit the same register in one cycle, set wins.
- Hazard: a used rs1/rs2 is pending and not being cleared this cycle, or the new load's rd is pending (WAW). A clear only counts when DECODE_WB_BYPASS_EN is defined. stall_o = if_valid_i && hazard.
- advance = !ex_valid_o || ex_ready_i.
- if_ready_o = advance && !hazard && !flush_i.
- Issue = if_valid_i && if_ready_o. It loads the output register and sets ex_valid_o.
- advance without issue clears ex_valid_o.
- Hold (ex_valid_o && !ex_ready_i): the bundle is frozen, except that on a WB write with wb_addr_i equal to a nonzero ex_rs1_addr_o / ex_rs2_addr_o, the matching data field is replaced with wb_data_i.
- flush_i has priority over issue and hold: ex_valid_o goes to 0 next cycle.
- NUM_REGS=16: any used rs/rd index ≥16 sets ex_illegal_o and forces ex_reg_write_o=0 and ex_mem_write_o=0.

## Timing
- Reset: ex_valid_o=0, all ex_* outputs 0, every scoreboard bit 0, register file all zeros. Combinational outputs if_ready_o and stall_o follow their equations.
- Issue to ex_valid_o: 1 cycle.
- Load-use: a dependent instruction issues in the cycle its load's WB occurs when bypass is on, and in the cycle after when it is off.
- Reset mid-operation drops everything in flight, with no partial state.

## Configuration
- DECODE_WB_BYPASS_EN defined: a read of a register being written this cycle returns wb_data_i, and a same-cycle scoreboard clear unblocks issue.
- Undefined: reads return the old register value and the hazard ignores same-cycle clears, costing one extra stall cycle per load-use.

## Structure
- decode_pkg holds:
  - the opcode constants;
  - id_ex_bundle_t, a packed struct of all ex_* fields;
  - RESULT_SRC_LOAD = 2'b01.
- Sub-module load_scoreboard holds the pending bits, set/clear/flush-clear and the hazard query.
- Reuses the existing control_unit and immediate_generator.

## Test plan
- Reset then `addi x1,x0,5` with ex_ready_i=1 -> ex_valid_o=1 next cycle, ex_imm_o=5, ex_rd_addr_o=1.
- `lw x2,0(x1)` issued, then `add x3,x2,x2` -> stall_o=1 until WB (wb_load_i=1, x2=0xDEAD). Bypass on: issues that cycle with rs1/rs2 data 0xDEAD. Bypass off: issues one cycle later.
- ex_ready_i=0 holding `sub x4,x5,x6` while WB writes x5=0x77 -> ex_rs1_data_o becomes 0x77, the rest of the bundle is unchanged, if_ready_o=0.
- A load to x7 in the output register plus flush_i -> ex_valid_o=0 next cycle, x7 not pending, and `add x8,x7,x0` issues with no stall.
- NUM_REGS=16 with `add x17,x1,x2` -> ex_illegal_o=1 and ex_reg_write_o=0.
